// File: rtl/pause_pkg.sv
// Shared types and defaults for the CPU pause gate.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pause_pkg;

  // Gate FSM states; the encoding is visible on state_dbg.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } pause_state_t;

  // Qualified ce_in pulses to wait for an opcode fetch before forcing the halt.
  localparam int DRAIN_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/cpu_pause_gate_edge_rise.sv
// One-flop rising-edge detector.
// Latency: combinational rise output, one-cycle history register.
// Backpressure: none; samples every clk_sys cycle.
module edge_rise (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic q;

  // History flop. Reset loads the live input so no false edge follows reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      q <= d;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/cpu_pause_gate.sv
// Halts the CPU clock-enable at an opcode-fetch boundary, with frame-step support.
// Latency: ce_out is combinational from ce_in; paused/state update one clk_sys after the decision.
// Backpressure: none; ce_in pulses are either passed or dropped, never queued.
module cpu_pause_gate
  import pause_pkg::*;
#(
  parameter  int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
  localparam int TW            = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pause_cpu,
  input  logic       step,
  input  logic       ce_in,
  input  logic       cpu_m1,
  input  logic       vblank,
  output logic       ce_out,
  output logic       paused,
  output logic [1:0] state_dbg
);

  localparam logic [TW-1:0] CNT_LAST = TW'(DRAIN_TIMEOUT - 1);

  pause_state_t  state;
  pause_state_t  state_nxt;
  logic          run_gate;
  logic          run_gate_nxt;
  logic          paused_nxt;
  logic [TW-1:0] drain_cnt;
  logic [TW-1:0] drain_cnt_nxt;
  logic          halt_mask;
  logic          step_rise;
  logic          vblank_rise;

  edge_rise u_step_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (step),
    .rise    (step_rise)
  );

  edge_rise u_vblank_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (vblank),
    .rise    (vblank_rise)
  );

  // Next-state, gate and counter decisions; halt_mask kills the pulse that ends a drain.
  always_comb begin
    state_nxt     = state;
    run_gate_nxt  = run_gate;
    paused_nxt    = paused;
    drain_cnt_nxt = drain_cnt;
    halt_mask     = 1'b0;
    case (state)
      ST_RUN: begin
        run_gate_nxt = 1'b1;
        paused_nxt   = 1'b0;
        if (pause_cpu) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (!pause_cpu) begin
          // Abort wins over a boundary in the same cycle; the pulse passes.
          state_nxt     = ST_RUN;
          drain_cnt_nxt = '0;
        end else if (ce_in) begin
          if (cpu_m1 || (drain_cnt == CNT_LAST)) begin
            halt_mask    = 1'b1;
            state_nxt    = ST_HALT;
            run_gate_nxt = 1'b0;
            paused_nxt   = 1'b1;
          end else begin
            // Below CNT_LAST here, so the increment saturates by construction.
            drain_cnt_nxt = drain_cnt + 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (!pause_cpu) begin
          state_nxt    = ST_RUN;
          run_gate_nxt = 1'b1;
          paused_nxt   = 1'b0;
        end else if (step_rise) begin
          state_nxt    = ST_STEP;
          run_gate_nxt = 1'b1;
          paused_nxt   = 1'b0;
        end
      end
      ST_STEP: begin
        if (!pause_cpu) begin
          state_nxt = ST_RUN;
        end else if (vblank_rise) begin
          // Frame done: drain again and re-halt at the next boundary.
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State, gate, acknowledge and drain counter registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      run_gate  <= 1'b1;
      paused    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      run_gate  <= run_gate_nxt;
      paused    <= paused_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  assign ce_out    = ce_in & run_gate & ~halt_mask;
  assign state_dbg = state;

endmodule
